// File: rtl/d_shift_register.sv
// rtl/d_shift_register.sv - WIDTH-bit D register with preset, enable and universal shift/rotate/load
module d_shift_register #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INV  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    logic [WIDTH-1:0] q_next;

    // Full next-state including reset/preset, so zero can be registered from it.
    always_comb begin
        q_next = q;
        if (!clr_n) begin
            q_next = RESET_VAL;
        end else if (pre) begin
            q_next = PRESET_VAL;
        end else if (en) begin
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_LOAD: q_next = d;
                MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
                MODE_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
                MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
                MODE_INV:  q_next = ~q;
                MODE_CLR:  q_next = '0;
                default:   q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        q    <= q_next;
        zero <= (q_next == '0);
    end

    assign q_n       = ~q;
    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

endmodule

// File: tb/tb_d_shift_register.sv
// tb/tb_d_shift_register.sv - randomized self-checking bench for d_shift_register (8-bit and 16-bit)
module tb_d_shift_register;

    logic        clk = 1'b0;
    logic        clr_n, pre, en, sir, sil;
    logic [2:0]  mode;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [7:0]  q8, qn8;
    logic [15:0] q16, qn16;
    logic        sol8, sor8, z8, sol16, sor16, z16;

    int unsigned m8, m16;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    d_shift_register u_dut8 (
        .clk(clk), .clr_n(clr_n), .pre(pre), .en(en), .mode(mode), .d(d8),
        .ser_in_r(sir), .ser_in_l(sil), .q(q8), .q_n(qn8),
        .ser_out_l(sol8), .ser_out_r(sor8), .zero(z8)
    );

    d_shift_register #(.WIDTH(16), .RESET_VAL(16'h1234), .PRESET_VAL(16'hFFFF)) u_dut16 (
        .clk(clk), .clr_n(clr_n), .pre(pre), .en(en), .mode(mode), .d(d16),
        .ser_in_r(sir), .ser_in_l(sil), .q(q16), .q_n(qn16),
        .ser_out_l(sol16), .ser_out_r(sor16), .zero(z16)
    );

    // Register value treated as an integer in [0, 2^w); shifts and rotates as multiply/divide.
    function automatic int unsigned model_next(int w, int unsigned rv, int unsigned pv,
                                               int unsigned cur, bit c, bit p, bit e,
                                               bit [2:0] md, int unsigned dv, bit sl, bit sr);
        int unsigned full = 32'd1 << w;
        int unsigned half = full / 2;
        if (!c) return rv;
        if (p)  return pv;
        if (!e) return cur;
        case (md)
            3'd0: return cur;
            3'd1: return dv % full;
            3'd2: return (cur * 2 + sr) % full;
            3'd3: return cur / 2 + sl * half;
            3'd4: return (cur * 2) % full + cur / half;
            3'd5: return cur / 2 + (cur % 2) * half;
            3'd6: return (full - 1) - cur;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        m8  = model_next(8,  32'h0,    32'hFF,   m8,  clr_n, pre, en, mode, 32'(d8),  sil, sir);
        m16 = model_next(16, 32'h1234, 32'hFFFF, m16, clr_n, pre, en, mode, 32'(d16), sil, sir);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v8, input logic [15:0] v16);
        clr_n = 1'b1; pre = 1'b0; en = 1'b1; mode = 3'b001; d8 = v8; d16 = v16;
        tick();
    endtask

    task automatic test_reset();
        clr_n = 1'b0; pre = 1'b1; en = 1'b1; mode = 3'b001; d8 = 8'hA5; d16 = 16'h5A5A;
        sir = 1'b0; sil = 1'b0;
        m8 = 0; m16 = 0;
        tick();
        tick();
        n_cmp++; if (q8 !== 8'h00)    begin n_err++; $display("FAIL reset_q8: got %h expected %h", q8, 8'h00); end
        n_cmp++; if (qn8 !== 8'hFF)   begin n_err++; $display("FAIL reset_qn8: got %h expected %h", qn8, 8'hFF); end
        n_cmp++; if (z8 !== 1'b1)     begin n_err++; $display("FAIL reset_zero8: got %b expected 1", z8); end
        n_cmp++; if (q16 !== 16'h1234) begin n_err++; $display("FAIL reset_q16: got %h expected %h", q16, 16'h1234); end
        n_cmp++; if (qn16 !== 16'hEDCB) begin n_err++; $display("FAIL reset_qn16: got %h expected %h", qn16, 16'hEDCB); end
        n_cmp++; if (z16 !== 1'b0)    begin n_err++; $display("FAIL reset_zero16: got %b expected 0", z16); end
        clr_n = 1'b1; pre = 1'b0; mode = 3'b000;
        tick();
        n_cmp++; if (q8 !== 8'h00)    begin n_err++; $display("FAIL reset_hold_q8: got %h expected %h", q8, 8'h00); end
        n_cmp++; if (q16 !== 16'h1234) begin n_err++; $display("FAIL reset_hold_q16: got %h expected %h", q16, 16'h1234); end
    endtask

    task automatic test_load_preset_enable();
        load(8'h3C, 16'hBEEF);
        n_cmp++; if (q8 !== 8'h3C)  begin n_err++; $display("FAIL load_q8: got %h expected %h", q8, 8'h3C); end
        n_cmp++; if (qn8 !== 8'hC3) begin n_err++; $display("FAIL load_qn8: got %h expected %h", qn8, 8'hC3); end
        n_cmp++; if (q16 !== 16'hBEEF) begin n_err++; $display("FAIL load_q16: got %h expected %h", q16, 16'hBEEF); end
        en = 1'b0; d8 = 8'hFF; d16 = 16'h0000;
        tick();
        n_cmp++; if (q8 !== 8'h3C)  begin n_err++; $display("FAIL enable_hold_q8: got %h expected %h", q8, 8'h3C); end
        n_cmp++; if (q16 !== 16'hBEEF) begin n_err++; $display("FAIL enable_hold_q16: got %h expected %h", q16, 16'hBEEF); end
        pre = 1'b1; d8 = 8'h00;
        tick();
        n_cmp++; if (q8 !== 8'hFF)  begin n_err++; $display("FAIL preset_q8: got %h expected %h", q8, 8'hFF); end
        n_cmp++; if (z8 !== 1'b0)   begin n_err++; $display("FAIL preset_zero8: got %b expected 0", z8); end
        n_cmp++; if (q16 !== 16'hFFFF) begin n_err++; $display("FAIL preset_q16: got %h expected %h", q16, 16'hFFFF); end
        pre = 1'b0; en = 1'b1;
    endtask

    task automatic test_shift();
        load(8'h81, 16'h8001);
        n_cmp++; if (sol8 !== 1'b1) begin n_err++; $display("FAIL shl_ser_out_l_before: got %b expected 1", sol8); end
        mode = 3'b010; sir = 1'b0;
        tick();
        n_cmp++; if (q8 !== 8'h02) begin n_err++; $display("FAIL shl1_q8: got %h expected %h", q8, 8'h02); end
        sir = 1'b1;
        tick();
        n_cmp++; if (q8 !== 8'h05) begin n_err++; $display("FAIL shl2_q8: got %h expected %h", q8, 8'h05); end
        n_cmp++; if (sor8 !== 1'b1) begin n_err++; $display("FAIL shr_ser_out_r_before: got %b expected 1", sor8); end
        mode = 3'b011; sil = 1'b1;
        tick();
        n_cmp++; if (q8 !== 8'h82) begin n_err++; $display("FAIL shr_q8: got %h expected %h", q8, 8'h82); end
        n_cmp++; if (q16 !== 16'(m16)) begin n_err++; $display("FAIL shift_q16: got %h expected %h", q16, 16'(m16)); end
    endtask

    task automatic test_rotate();
        logic [15:0] start16;
        start16 = 16'($urandom);
        load(8'h01, start16);
        mode = 3'b100;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp8;
            exp8 = 8'(1 << ((i + 1) % 8));
            tick();
            n_cmp++; if (q8 !== exp8) begin n_err++; $display("FAIL rol_step%0d_q8: got %h expected %h", i, q8, exp8); end
            n_cmp++; if (q16 !== 16'(m16)) begin n_err++; $display("FAIL rol_step%0d_q16: got %h expected %h", i, q16, 16'(m16)); end
        end
        mode = 3'b101;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (q8 !== 8'h01) begin n_err++; $display("FAIL ror_wrap_q8: got %h expected %h", q8, 8'h01); end
        n_cmp++; if (q16 !== start16) begin n_err++; $display("FAIL rol_ror_return_q16: got %h expected %h", q16, start16); end
    endtask

    task automatic test_inv_clr();
        load(8'h0F, 16'h00FF);
        mode = 3'b110;
        tick();
        n_cmp++; if (q8 !== 8'hF0) begin n_err++; $display("FAIL inv_q8: got %h expected %h", q8, 8'hF0); end
        n_cmp++; if (z8 !== 1'b0)  begin n_err++; $display("FAIL inv_zero8: got %b expected 0", z8); end
        n_cmp++; if (q16 !== 16'hFF00) begin n_err++; $display("FAIL inv_q16: got %h expected %h", q16, 16'hFF00); end
        mode = 3'b111;
        tick();
        n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL clr_q8: got %h expected %h", q8, 8'h00); end
        n_cmp++; if (z8 !== 1'b1)  begin n_err++; $display("FAIL clr_zero8: got %b expected 1", z8); end
        n_cmp++; if (z16 !== 1'b1) begin n_err++; $display("FAIL clr_zero16: got %b expected 1", z16); end
    endtask

    task automatic test_reset_mid_shift();
        load(8'h81, 16'hC003);
        mode = 3'b100;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (q8 !== 8'(m8)) begin n_err++; $display("FAIL midrol_q8: got %h expected %h", q8, 8'(m8)); end
        clr_n = 1'b0;
        tick();
        n_cmp++; if (q8 !== 8'h00)     begin n_err++; $display("FAIL midreset_q8: got %h expected %h", q8, 8'h00); end
        n_cmp++; if (q16 !== 16'h1234) begin n_err++; $display("FAIL midreset_q16: got %h expected %h", q16, 16'h1234); end
        clr_n = 1'b1;
        tick();
        n_cmp++; if (q8 !== 8'h00)     begin n_err++; $display("FAIL resume_q8: got %h expected %h", q8, 8'h00); end
        n_cmp++; if (q16 !== 16'h2468) begin n_err++; $display("FAIL resume_q16: got %h expected %h", q16, 16'h2468); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            clr_n = ($urandom_range(0, 19) != 0);
            pre   = ($urandom_range(0, 14) == 0);
            en    = ($urandom_range(0, 5) != 0);
            mode  = 3'($urandom_range(0, 7));
            d8    = 8'($urandom);
            d16   = 16'($urandom);
            sir   = 1'($urandom);
            sil   = 1'($urandom);
            tick();
            n_cmp++; if (q8 !== 8'(m8)) begin n_err++; $display("FAIL rand%0d_q8: got %h expected %h", i, q8, 8'(m8)); end
            n_cmp++; if (qn8 !== ~8'(m8)) begin n_err++; $display("FAIL rand%0d_qn8: got %h expected %h", i, qn8, ~8'(m8)); end
            n_cmp++; if (sol8 !== 1'(m8 / 128)) begin n_err++; $display("FAIL rand%0d_sol8: got %b expected %b", i, sol8, 1'(m8 / 128)); end
            n_cmp++; if (sor8 !== 1'(m8 % 2)) begin n_err++; $display("FAIL rand%0d_sor8: got %b expected %b", i, sor8, 1'(m8 % 2)); end
            n_cmp++; if (z8 !== (m8 == 0)) begin n_err++; $display("FAIL rand%0d_zero8: got %b expected %b", i, z8, (m8 == 0)); end
            n_cmp++; if (q16 !== 16'(m16)) begin n_err++; $display("FAIL rand%0d_q16: got %h expected %h", i, q16, 16'(m16)); end
            n_cmp++; if (qn16 !== ~16'(m16)) begin n_err++; $display("FAIL rand%0d_qn16: got %h expected %h", i, qn16, ~16'(m16)); end
            n_cmp++; if (sol16 !== 1'(m16 / 32768)) begin n_err++; $display("FAIL rand%0d_sol16: got %b expected %b", i, sol16, 1'(m16 / 32768)); end
            n_cmp++; if (sor16 !== 1'(m16 % 2)) begin n_err++; $display("FAIL rand%0d_sor16: got %b expected %b", i, sor16, 1'(m16 % 2)); end
            n_cmp++; if (z16 !== (m16 == 0)) begin n_err++; $display("FAIL rand%0d_zero16: got %b expected %b", i, z16, (m16 == 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_load_preset_enable();
        test_shift();
        test_rotate();
        test_inv_clr();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d_shift_register.md
Name: d_shift_register

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register of D flip-flops with complementary outputs (q / q_n).
- Adds synchronous preset, clock enable, and a mode-selected universal shift/rotate/load datapath with serial in/out at both ends.
- Used as the team's generic storage/shift element for datapath staging, serialisers and LFSR-style experiments.

Parameters:
- WIDTH, 8, register width in bits, minimum 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q when clr_n is sampled low.
- PRESET_VAL, {WIDTH{1'b1}}, value loaded into q when pre is sampled high.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr_n  input  1  reset; synchronous, active-low.
- pre  input  1  synchronous preset, active-high.
- en  input  1  clock enable; when low, q holds.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- ser_in_r  input  1  serial input entering at bit 0 on a left shift.
- ser_in_l  input  1  serial input entering at bit WIDTH-1 on a right shift.
- q  output  WIDTH  register contents.
- q_n  output  WIDTH  bitwise complement of q; always equals ~q, including during and after reset.
- ser_out_l  output  1  q[WIDTH-1].
- ser_out_r  output  1  q[0].
- zero  output  1  registered flag; 1 when q is all zeros.

Behaviour:
- Single clock domain. No asynchronous paths. All outputs are registered or pure functions of q.
- Reset: with clr_n low at a rising edge, the next state is q=RESET_VAL, q_n=~RESET_VAL and zero=(RESET_VAL==0), independent of all other inputs.
- Reset mid-operation: any shift in progress is abandoned. The state is exactly the reset state on the edge after clr_n is sampled low.
- Priority at each rising edge, highest first:
  1. clr_n==0 → RESET_VAL.
  2. pre==1 → PRESET_VAL. pre ignores en.
  3. en==0 → hold.
  4. mode operation.
- mode encoding (en=1, pre=0, clr_n=1):
  - 000 HOLD: q unchanged.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], ser_in_r}.
  - 011 SHR: q <= {ser_in_l, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 INV: q <= ~q.
  - 111 CLR: q <= 0. This is an operational clear, distinct from reset.
- Latency: one cycle from the sampling edge to the updated q, q_n, ser_out_* and zero. Outputs are stable between edges.
- zero is registered alongside q: it is computed from the next-state value, so it is never a cycle behind q.
- Wrap-around:
  - ROL/ROR are lossless. After WIDTH consecutive rotates, q returns to its original value.
  - SHL/SHR discard the bit shifted out. That bit is visible on ser_out_l (SHL) or ser_out_r (SHR) during the cycle before the shift.
- Simultaneous events:
  - clr_n low with pre high → reset wins.
  - pre high with en low → preset is applied.
  - Illegal or X mode is not permitted; RTL treats the default branch as HOLD.
- No internal state beyond q (and zero). There is no FSM beyond the mode mux; the sequential behaviour is the register plus shift chain.

Test Plan:
- Reset: apply clr_n=0 for 2 cycles with pre=1, en=1, mode=001, d=8'hA5 → q=8'h00, q_n=8'hFF, zero=1. Release clr_n; hold mode=000 → q stays 8'h00.
- Load/preset/enable: mode=001, d=8'h3C, en=1 → q=8'h3C, q_n=8'hC3 after 1 edge. Set en=0, d=8'hFF → q holds 8'h3C. Set pre=1, en=0 → q=8'hFF, zero=0.
- Shift: load 8'h81, then mode=010 with ser_in_r=0 for 1 edge → q=8'h02. Before that edge, ser_out_l was 1.
  Continue: 1 more SHL edge with ser_in_r=1 → q=8'h05. Then mode=011 with ser_in_l=1 → q=8'h82.
- Rotate wrap: load 8'h01, run 8 ROL edges → q sequence is 02, 04, …, 80, 01. Run 8 ROR edges → q returns to 8'h01.
- INV/CLR and zero timing: load 8'h0F, mode=110 → q=8'hF0. Then mode=111 → q=8'h00 with zero=1 on the same edge.
- Reset mid-shift: during ROL, assert clr_n=0 for 1 edge → q=RESET_VAL on that edge. The next edge resumes the mode operation from RESET_VAL. Repeat with WIDTH=16 and RESET_VAL=16'h1234.
